read_logic: RTL
===============

# read_logic

Read-side pointer controller for the asynchronous FIFO, in the read clock domain. It accepts read requests and gates them against a registered empty flag. It maintains the binary read address for the storage array and publishes a Gray-coded read pointer for the write domain. It also synchronizes the incoming Gray write pointer and flags valid read data one cycle after each accepted read.

## Interface
- width, 32: data width; carried for parameter consistency across FIFO blocks, no datapath here.
- depth, 8: FIFO depth in words; must be a power of two, at least 2.
- adr_width, $clog2(depth): storage address width; pointers are adr_width+1 bits.
- AE_THRESH, 1: almost-empty threshold in words; used only with FIFO_RD_LEVEL_EN.

- clk_r  in  1  read-domain clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  read request from the consumer.
- wr_ptr_gray  in  adr_width+1  Gray-coded write pointer, driven from the write-clock domain.
- read  out  1  accepted read, combinational: rd_en && !FIFO_empty; drives the memory read enable.
- read_adr  out  adr_width+1  registered binary read pointer; memory uses the low adr_width bits.
- rd_ptr_gray  out  adr_width+1  registered Gray form of read_adr, for the write-domain synchronizer.
- FIFO_empty  out  1  registered empty flag.
- data_valid  out  1  registered; high the cycle after read was high.
- rd_level  out  adr_width+1  words available, per the write pointer as seen in the read domain.
- almost_empty  out  1  rd_level <= AE_THRESH.

## Operation
- Synchronizer: wr_ptr_gray passes through 2 flops on clk_r to give wr_gray_s. No logic is allowed before the first flop.
- Next pointer: rd_bin_next = read_adr + read, mod 2^(adr_width+1). rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1).
- Empty: empty_next = (rd_gray_next == wr_gray_s).
- Each clk_r edge registers read_adr <= rd_bin_next, rd_ptr_gray <= rd_gray_next, FIFO_empty <= empty_next and data_valid <= read.
- No state machine; behaviour is held entirely in the pointer, flag and synchronizer registers.
- rd_en while FIFO_empty=1: read=0, pointers hold, data_valid=0 next cycle. This is not an error and has no sticky flag.
- Wrap-around: the pointer MSB toggles every depth reads. Gray comparison of the full adr_width+1 bits distinguishes empty from full. Wrapping never raises a spurious empty.
- Simultaneous last-word read and new write in flight: empty rises at the read edge. It falls again only once the new Gray pointer has crossed the synchronizer. This is the pessimistic direction and is correct.
- Reset values, all reached immediately on reset_n low with no clock needed:
  - read_adr=0, rd_ptr_gray=0, both sync flops=0
  - FIFO_empty=1, data_valid=0
  - rd_level=0, almost_empty=1
- read evaluates to 0 during reset because FIFO_empty=1.
- Reset deassertion is assumed synchronized to clk_r at top level.

## Timing
- Read to pointer: the edge that samples read=1 advances read_adr and rd_ptr_gray.
- Read to empty: if that read takes the last word, FIFO_empty rises at the same edge.
- Write to non-empty: FIFO_empty falls at the 3rd clk_r rising edge after wr_ptr_gray changes (2 sync stages, then the flag register).
- Read to data: data_valid is high exactly 1 cycle after read, matching the synchronous-read memory latency.
- Back-to-back reads at 1 per cycle are sustained while not empty.

## Configuration
- FIFO_RD_LEVEL_EN defined:
  - rd_level = gray2bin(wr_gray_s) - read_adr, mod 2^(adr_width+1), combinational from registers.
  - almost_empty = (rd_level <= AE_THRESH).
- FIFO_RD_LEVEL_EN undefined:
  - the level subtractor and gray2bin are not built.
  - rd_level ties to 0 and almost_empty = FIFO_empty.
  - The ports remain so that top-level instantiation is unchanged.

## Structure
- Shared package fifo_pkg holds:
  - the bin2gray and gray2bin functions, parameterized by width
  - the pointer-width rule adr_width+1
  - the default depth constant, shared with the write side.
- Sub-module sync_2ff: a parameterized-width two-flop synchronizer with async active-low reset. The write side reuses it for rd_ptr_gray.

## Test plan
- Reset: hold reset_n=0 with rd_en=1 and wr_ptr_gray=4'b0011 -> FIFO_empty=1, read=0, read_adr=0, rd_ptr_gray=0, data_valid=0.
- Single word (depth=8): wr_ptr_gray 0->4'b0001 -> FIFO_empty falls after the 3rd edge. With rd_en=1: read=1 for 1 cycle, read_adr becomes 1, rd_ptr_gray=4'b0001, FIFO_empty rises at that edge, data_valid=1 the next cycle.
- Full drain: wr_ptr_gray=4'b1100 (8 words), rd_en held high -> 8 consecutive reads, read_adr goes 0 through 8, and FIFO_empty rises at the 8th read edge. The 9th request gives read=0.
- Wrap-around: stream 20 words with the write pointer leading by 1-3 -> read_adr wraps 15->0 and rd_ptr_gray goes 4'b1000->4'b0000. No empty is asserted while the write pointer leads, and every read is followed by data_valid.
- Async reset mid-stream: after 3 reads, pull reset_n low between clock edges -> all outputs reach their reset values before the next edge. After release, reading restarts at read_adr=0.
- Level (with FIFO_RD_LEVEL_EN, AE_THRESH=1): 5 words written, then 3 reads -> rd_level=2 and almost_empty=0. After 1 more read, rd_level=1 and almost_empty=1. Without the macro, rd_level=0 and almost_empty tracks FIFO_empty.

Source files
------------

// File: rtl/fifo_pkg.sv
// Definitions shared by the read and write sides of the asynchronous FIFO:
// default depth, pointer-width rule and Gray/binary conversion helpers.
package fifo_pkg;

   localparam int FIFO_DEPTH_DEFAULT = 8;
   localparam int GRAY_MAX_W         = 32;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   function automatic int ptr_width(input int adr_w);
      return adr_w + 1;
   endfunction

   // Width-generic: callers zero-extend into GRAY_MAX_W bits and truncate the result.
   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b = '0;
      for (int i = 0; i < GRAY_MAX_W; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for multi-bit Gray pointers crossing clock domains.
// The input feeds the first flop directly; no logic may be placed ahead of it.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/read_logic.sv
// Read-domain pointer controller of the asynchronous FIFO: gates reads against the
// registered empty flag, publishes the Gray read pointer. Level outputs: FIFO_RD_LEVEL_EN.
module read_logic
   import fifo_pkg::*;
#(
   parameter int width     = 32,
   parameter int depth     = FIFO_DEPTH_DEFAULT,
   parameter int adr_width = $clog2(depth),
   parameter int AE_THRESH = 1
) (
   input  logic               clk_r,
   input  logic               reset_n,
   input  logic               rd_en,
   input  logic [adr_width:0] wr_ptr_gray,
   output logic               read,
   output logic [adr_width:0] read_adr,
   output logic [adr_width:0] rd_ptr_gray,
   output logic               FIFO_empty,
   output logic               data_valid,
   output logic [adr_width:0] rd_level,
   output logic               almost_empty
);

   localparam int PW = ptr_width(adr_width);

   if (depth < 2 || (depth & (depth - 1)) != 0 || width < 1 || AE_THRESH < 0) begin : g_bad_cfg
      $error("read_logic: depth must be a power of two >= 2, width >= 1, AE_THRESH >= 0");
   end

   logic [PW-1:0] wr_gray_s;
   logic [PW-1:0] read_adr_q, read_adr_d;
   logic [PW-1:0] rd_gray_q, rd_gray_d;
   logic          empty_q, empty_d;
   logic          dvld_q;

   sync_2ff #(.W(PW)) u_wr_sync (
      .clk_i  (clk_r),
      .rst_ni (reset_n),
      .d_i    (wr_ptr_gray),
      .q_o    (wr_gray_s)
   );

   assign read = rd_en && !empty_q;

   // Empty is judged on the post-read pointer, so taking the last word raises it at once.
   always_comb begin
      read_adr_d = read_adr_q + PW'(read);
      rd_gray_d  = PW'(bin2gray(GRAY_MAX_W'(read_adr_d)));
      empty_d    = (rd_gray_d == wr_gray_s);
   end

   always_ff @(posedge clk_r or negedge reset_n) begin
      if (!reset_n) begin
         read_adr_q <= '0;
         rd_gray_q  <= '0;
         empty_q    <= 1'b1;
         dvld_q     <= 1'b0;
      end else begin
         read_adr_q <= read_adr_d;
         rd_gray_q  <= rd_gray_d;
         empty_q    <= empty_d;
         dvld_q     <= read;
      end
   end

   assign read_adr    = read_adr_q;
   assign rd_ptr_gray = rd_gray_q;
   assign FIFO_empty  = empty_q;
   assign data_valid  = dvld_q;

`ifdef FIFO_RD_LEVEL_EN
   localparam logic [GRAY_MAX_W-1:0] AE_LIM = GRAY_MAX_W'(AE_THRESH);

   logic [PW-1:0] wr_bin_s;

   assign wr_bin_s     = PW'(gray2bin(GRAY_MAX_W'(wr_gray_s)));
   assign rd_level     = wr_bin_s - read_adr_q;
   assign almost_empty = (GRAY_MAX_W'(rd_level) <= AE_LIM);
`else
   assign rd_level     = '0;
   assign almost_empty = empty_q;
`endif

endmodule
